// File: rtl/delay_scheduler.sv
// Delayed-response scheduler: each accepted request responds exactly D cycles later.
// A slot wheel reserves completion cycles so at most one response lands per cycle.
module delay_scheduler #(
  parameter int MAX_DELAY       = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = 4,
  parameter int DLY_W           = $clog2(MAX_DELAY + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_multi,
  input  logic [DLY_W-1:0]                     cfg_delay,
  input  logic                                 req_valid,
  input  logic [TAG_W-1:0]                     req_tag,
  output logic                                 req_ready,
  output logic                                 rsp_valid,
  output logic [TAG_W-1:0]                     rsp_tag,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [7:0]                           stall_cnt
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  // slot j holds the request whose response registers at the (j+1)-th upcoming edge
  logic             slot_valid_r [MAX_DELAY];
  logic [TAG_W-1:0] slot_tag_r   [MAX_DELAY];

  logic [DLY_W-1:0] d_eff_s;
  logic             fire_s;
  logic             slot_free_s;
  logic             accept_s;

  // Clamp the requested delay into 1..MAX_DELAY
  always_comb begin
    d_eff_s = cfg_delay;
    if (cfg_delay == {DLY_W{1'b0}}) begin
      d_eff_s = DLY_W'(1);
    end else if (cfg_delay > DLY_W'(MAX_DELAY)) begin
      d_eff_s = DLY_W'(MAX_DELAY);
    end else begin
      d_eff_s = cfg_delay;
    end
  end

  // Completion cycle k+D is free when nothing sits one slot beyond D-1 before the shift
  always_comb begin
    slot_free_s = 1'b1;
    for (int j = 1; j < MAX_DELAY; j++) begin
      if (d_eff_s == DLY_W'(j)) begin
        slot_free_s = !slot_valid_r[j];
      end else begin
        slot_free_s = slot_free_s;
      end
    end
  end

  assign fire_s = slot_valid_r[0];

  // Acceptance decision, independent of req_valid
  always_comb begin
    req_ready = 1'b0;
    if (!rst_n) begin
      req_ready = 1'b0;
    end else if (!cfg_multi) begin
      req_ready = (outstanding == OUT_W'(0)) ||
                  ((outstanding == OUT_W'(1)) && fire_s);
    end else begin
      req_ready = ((outstanding < OUT_W'(MAX_OUTSTANDING)) || fire_s) && slot_free_s;
    end
  end

  assign accept_s = req_valid && req_ready;

  // Wheel advance, response register, in-flight and stall counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < MAX_DELAY; j++) begin
        slot_valid_r[j] <= 1'b0;
        slot_tag_r[j]   <= {TAG_W{1'b0}};
      end
      rsp_valid   <= 1'b0;
      rsp_tag     <= {TAG_W{1'b0}};
      outstanding <= {OUT_W{1'b0}};
      stall_cnt   <= 8'd0;
    end else begin
      rsp_valid <= slot_valid_r[0];
      rsp_tag   <= slot_valid_r[0] ? slot_tag_r[0] : {TAG_W{1'b0}};
      for (int j = 0; j < MAX_DELAY - 1; j++) begin
        slot_valid_r[j] <= slot_valid_r[j+1];
        slot_tag_r[j]   <= slot_tag_r[j+1];
      end
      slot_valid_r[MAX_DELAY-1] <= 1'b0;
      slot_tag_r[MAX_DELAY-1]   <= {TAG_W{1'b0}};
      // a new reservation overrides the shifted-in value of its slot
      if (accept_s) begin
        for (int j = 0; j < MAX_DELAY; j++) begin
          if (d_eff_s == DLY_W'(j + 1)) begin
            slot_valid_r[j] <= 1'b1;
            slot_tag_r[j]   <= req_tag;
          end
        end
      end
      case ({accept_s, fire_s})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (req_valid && !req_ready && (stall_cnt != 8'd255)) begin
        stall_cnt <= stall_cnt + 8'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// Self-checking bench for delay_scheduler: directed scenarios then random traffic,
// all checked against a queue-of-due-cycles reference model.
module tb_delay_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_multi = 1'b0;
  logic [3:0] cfg_delay = 4'd1;
  logic       req_valid = 1'b0;
  logic [3:0] req_tag = 4'd0;
  logic       req_ready;
  logic       rsp_valid;
  logic [3:0] rsp_tag;
  logic [2:0] outstanding;
  logic [7:0] stall_cnt;

  delay_scheduler #(.MAX_DELAY(8), .MAX_OUTSTANDING(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_multi(cfg_multi), .cfg_delay(cfg_delay),
    .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .outstanding(outstanding),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int due_q[$];
  logic [3:0] tag_q[$];
  int m_stall = 0;
  logic last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", name, obs, exp, cyc);
    end
  endtask

  function automatic int eff(input int c);
    if (c == 0) return 1;
    if (c > 8) return 8;
    return c;
  endfunction

  // One clock cycle: drive, check req_ready, advance model, check registered outputs
  task automatic tick(input logic v, input logic [3:0] tg, input logic [3:0] dly, input logic mul);
    int d, n;
    logic fire_m, free_m, exp_rdy, acc, rv;
    logic [3:0] rtag;
    req_valid = v; req_tag = tg; cfg_delay = dly; cfg_multi = mul;
    #2;
    d = eff(int'(dly));
    n = due_q.size();
    fire_m = 1'b0;
    free_m = 1'b1;
    foreach (due_q[i]) begin
      if (due_q[i] == cyc + 1) fire_m = 1'b1;
      if (due_q[i] == cyc + 1 + d) free_m = 1'b0;
    end
    if (!rst_n) exp_rdy = 1'b0;
    else if (!mul) exp_rdy = (n == 0) || (n == 1 && fire_m);
    else exp_rdy = (n < 4 || fire_m) && free_m;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    cyc++;
    rv = 1'b0;
    rtag = 4'd0;
    if (!rst_n) begin
      due_q.delete();
      tag_q.delete();
      m_stall = 0;
      acc = 1'b0;
    end else begin
      for (int i = due_q.size() - 1; i >= 0; i--) begin
        if (due_q[i] == cyc) begin
          rv = 1'b1;
          rtag = tag_q[i];
          due_q.delete(i);
          tag_q.delete(i);
        end
      end
      if (v && !exp_rdy && m_stall < 255) m_stall++;
      if (acc) begin
        due_q.push_back(cyc + d);
        tag_q.push_back(tg);
      end
    end
    last_acc = acc;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(rv));
    if (rv || !rst_n) chk("rsp_tag", 32'(rsp_tag), 32'(rtag));
    chk("outstanding", 32'(outstanding), 32'(due_q.size()));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 4'd0, 4'd1, 1'b0);
    rst_n = 1'b1;
  endtask

  // Offer one request and hold it until accepted, with a bounded wait
  task automatic send(input logic [3:0] tg, input logic [3:0] dly, input logic mul);
    for (int t = 0; t < 40; t++) begin
      tick(1'b1, tg, dly, mul);
      if (last_acc) return;
    end
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 4'd1, cfg_multi);
  endtask

  initial begin
    logic pend;
    logic [3:0] ptag, pdly;
    logic pmul;

    rst_n = 1'b0;
    tick(1'b0, 4'd0, 4'd1, 1'b0);
    tick(1'b1, 4'd3, 4'd1, 1'b0);
    rst_n = 1'b1;
    chk("reset_stall", 32'(stall_cnt), 32'd0);

    // single mode, D = 1: back-to-back accepts
    send(4'd5, 4'd1, 1'b0);
    send(4'd6, 4'd1, 1'b0);
    chk("single_d1_out", 32'(outstanding), 32'd1);
    idle(3);

    // single mode, D = 3: two stall cycles before the next accept
    do_reset();
    send(4'd2, 4'd3, 1'b0);
    send(4'd7, 4'd3, 1'b0);
    idle(4);
    chk("single_d3_stall", 32'(stall_cnt), 32'd2);

    // multi mode, D = 3, five tags against an in-flight limit of four
    do_reset();
    for (int t = 0; t < 5; t++) send(4'(t), 4'd3, 1'b1);
    idle(5);

    // multi collision: A with D=4, then B with D=3 blocked one cycle
    do_reset();
    send(4'd10, 4'd4, 1'b1);
    send(4'd11, 4'd3, 1'b1);
    idle(6);
    chk("collision_stall", 32'(stall_cnt), 32'd1);

    // clamping of delay 0 and delay above MAX_DELAY
    do_reset();
    send(4'd1, 4'd0, 1'b1);
    idle(2);
    send(4'd9, 4'd15, 1'b1);
    idle(9);

    // reset while two requests are in flight
    do_reset();
    send(4'd4, 4'd5, 1'b1);
    send(4'd8, 4'd6, 1'b1);
    tick(1'b0, 4'd0, 4'd1, 1'b1);
    do_reset();
    chk("midreset_out", 32'(outstanding), 32'd0);
    idle(8);
    send(4'd12, 4'd2, 1'b1);
    idle(3);

    // multi -> single switch with several in flight
    do_reset();
    send(4'd1, 4'd6, 1'b1);
    send(4'd2, 4'd7, 1'b1);
    send(4'd3, 4'd8, 1'b1);
    send(4'd4, 4'd2, 1'b0);
    idle(9);

    // stall counter saturation: single mode with D = 8 under constant pressure
    do_reset();
    for (int i = 0; i < 300; i++) tick(1'b1, 4'(i), 4'd8, 1'b0);
    chk("stall_sat", 32'(stall_cnt), 32'd255);

    // random traffic
    do_reset();
    pend = 1'b0;
    ptag = 4'd0;
    pdly = 4'd1;
    pmul = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 97 == 0) pmul = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        pend = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      if (!pend) begin
        pend = $urandom_range(0, 3) != 0;
        ptag = 4'($urandom);
      end
      pdly = 4'($urandom_range(0, 15));
      tick(pend, ptag, pdly, pmul);
      if (last_acc || !rst_n) pend = 1'b0;
    end
    rst_n = 1'b1;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
